// File: rtl/spi_slave_regif.sv
// spi_slave_regif
//   SPI mode-0 slave front end for the MCU->FPGA control link, running in the
//   sampling clock domain (clkout0). sclk/mosi/cs_n are oversampled through a
//   flip-flop synchroniser. Frames are a command byte {rw, addr} followed by
//   data bytes. Write frames issue register write strobes. Read frames issue
//   read requests and return the read data on miso.
//
// Ports
//   clk_i        sampling clock (sole clock)
//   rst_i        synchronous active-high reset
//   sclk_i       SPI clock (asynchronous)
//   mosi_i       SPI data in, MSB first
//   cs_n_i       SPI chip select, active low
//   miso_o       SPI data out, MSB first
//   miso_oe_o    miso output enable while a frame is active
//   wr_valid_o   one-cycle write strobe with wr_addr_o / wr_data_o
//   rd_req_o     one-cycle read request with rd_addr_o
//   rd_data_i    read data, sampled RD_LAT cycles after rd_req_o
//   frame_err_o  one-cycle pulse when cs_n rises mid-byte
//   busy_o       high while the front end is not idle

`timescale 1ns/1ps

module spi_slave_regif #(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RD_LAT      = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sclk_i,
    input  logic              mosi_i,
    input  logic              cs_n_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    output logic              wr_valid_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o,
    output logic              rd_req_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [7:0]        rd_data_i,
    output logic              frame_err_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        WAIT_HI,
        IDLE,
        CMD,
        DATA
    } state_t;

    state_t state;

    // Synchroniser chains, all the same depth so edges and data line up.
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sclk_d;
    logic                   cs_d;

    logic sclk_s;
    logic mosi_s;
    logic cs_s;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;

    logic [6:0]        rx_sr;
    logic [7:0]        rx_byte;
    logic [2:0]        bit_cnt;
    logic [2:0]        bit_cnt_nxt;
    logic [7:0]        tx_sr;
    logic              skip_fall;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_inc;
    logic              rw;
    logic              ld_pend;
    logic [1:0]        ld_cnt;

    // cs sync resets to 0 so WAIT_HI only leaves once the real pin is seen
    // high; this keeps a reset in the middle of a frame from re-triggering.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync[0] <= sclk_i;
            mosi_sync[0] <= mosi_i;
            cs_sync[0]   <= cs_n_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sclk_sync[i] <= sclk_sync[i-1];
                mosi_sync[i] <= mosi_sync[i-1];
                cs_sync[i]   <= cs_sync[i-1];
            end
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    assign rx_byte     = {rx_sr, mosi_s};
    assign addr_inc    = addr + ADDR_W'(1);
    // Bit count as it stands once this cycle's rise (if any) is counted;
    // a wrap to 0 means the byte just completed cleanly.
    assign bit_cnt_nxt = sclk_rise ? bit_cnt + 3'd1 : bit_cnt;

    assign miso_o    = tx_sr[7];
    assign miso_oe_o = ((state == CMD) || (state == DATA)) && !cs_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= WAIT_HI;
            rx_sr       <= '0;
            bit_cnt     <= '0;
            tx_sr       <= '0;
            skip_fall   <= 1'b0;
            addr        <= '0;
            rw          <= 1'b0;
            ld_pend     <= 1'b0;
            ld_cnt      <= '0;
            wr_valid_o  <= 1'b0;
            wr_addr_o   <= '0;
            wr_data_o   <= '0;
            rd_req_o    <= 1'b0;
            rd_addr_o   <= '0;
            frame_err_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            wr_valid_o  <= 1'b0;
            rd_req_o    <= 1'b0;
            frame_err_o <= 1'b0;
            // Registered from the current state so busy_o reads 0 in the
            // cycle after reset, like every other output.
            busy_o      <= (state != IDLE);

            case (state)
                WAIT_HI: begin
                    if (cs_s) begin
                        state <= IDLE;
                    end
                end

                IDLE: begin
                    if (cs_fall) begin
                        state     <= CMD;
                        bit_cnt   <= '0;
                        rx_sr     <= '0;
                        tx_sr     <= '0;
                        skip_fall <= 1'b0;
                        ld_pend   <= 1'b0;
                    end
                end

                CMD, DATA: begin
                    if (sclk_rise) begin
                        rx_sr   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt_nxt;
                        if (bit_cnt == 3'd7) begin
                            if (state == CMD) begin
                                rw    <= rx_byte[7];
                                addr  <= rx_byte[ADDR_W-1:0];
                                state <= DATA;
                                if (rx_byte[7]) begin
                                    rd_req_o  <= 1'b1;
                                    rd_addr_o <= rx_byte[ADDR_W-1:0];
                                    ld_pend   <= 1'b1;
                                    ld_cnt    <= 2'(RD_LAT);
                                end
                            end else if (!rw) begin
                                wr_valid_o <= 1'b1;
                                wr_addr_o  <= addr;
                                wr_data_o  <= rx_byte;
                                addr       <= addr_inc;
                            end else begin
                                addr      <= addr_inc;
                                rd_req_o  <= 1'b1;
                                rd_addr_o <= addr_inc;
                                ld_pend   <= 1'b1;
                                ld_cnt    <= 2'(RD_LAT);
                            end
                        end
                    end

                    // Read data arrives RD_LAT cycles after the request.
                    // The fall right after a load is skipped so bit 7 is
                    // presented for a full sclk period.
                    if (ld_pend && (ld_cnt == 2'd0)) begin
                        tx_sr     <= rd_data_i;
                        skip_fall <= 1'b1;
                        ld_pend   <= 1'b0;
                    end else begin
                        if (ld_pend) begin
                            ld_cnt <= ld_cnt - 2'd1;
                        end
                        if (sclk_fall) begin
                            if (skip_fall) begin
                                skip_fall <= 1'b0;
                            end else begin
                                tx_sr <= {tx_sr[6:0], 1'b0};
                            end
                        end
                    end

                    // Last so it overrides the state change and any pending
                    // load issued above; a byte completing in this same
                    // cycle still gets its strobe.
                    if (cs_rise) begin
                        state       <= IDLE;
                        tx_sr       <= '0;
                        skip_fall   <= 1'b0;
                        ld_pend     <= 1'b0;
                        bit_cnt     <= '0;
                        frame_err_o <= (bit_cnt_nxt != 3'd0);
                    end
                end

                default: state <= WAIT_HI;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_regif.sv
// tb_spi_slave_regif
//   Directed bench for spi_slave_regif: bit-banged SPI master, a read-side
//   register model with one cycle of latency, and a strobe monitor.

`timescale 1ns/1ps

module tb_spi_slave_regif;

    localparam time HALF = 80ns;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       sclk_i;
    logic       mosi_i;
    logic       cs_n_i;
    logic       miso_o;
    logic       miso_oe_o;
    logic       wr_valid_o;
    logic [6:0] wr_addr_o;
    logic [7:0] wr_data_o;
    logic       rd_req_o;
    logic [6:0] rd_addr_o;
    logic [7:0] rd_data_i;
    logic       frame_err_o;
    logic       busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] wr_a_q[$];
    logic [7:0] wr_d_q[$];
    logic [6:0] rd_a_q[$];
    int         ferr_cnt;

    always #5 clk = ~clk;

    spi_slave_regif #(
        .ADDR_W     (7),
        .SYNC_STAGES(2),
        .RD_LAT     (1)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .sclk_i     (sclk_i),
        .mosi_i     (mosi_i),
        .cs_n_i     (cs_n_i),
        .miso_o     (miso_o),
        .miso_oe_o  (miso_oe_o),
        .wr_valid_o (wr_valid_o),
        .wr_addr_o  (wr_addr_o),
        .wr_data_o  (wr_data_o),
        .rd_req_o   (rd_req_o),
        .rd_addr_o  (rd_addr_o),
        .rd_data_i  (rd_data_i),
        .frame_err_o(frame_err_o),
        .busy_o     (busy_o)
    );

    function automatic logic [7:0] reg_val(input logic [6:0] a);
        case (a)
            7'h05:   return 8'h5A;
            7'h06:   return 8'hC3;
            default: return 8'hEE;
        endcase
    endfunction

    // Register file read port: data valid exactly one cycle after the
    // request, 0 otherwise.
    always @(posedge clk) begin
        rd_data_i <= rd_req_o ? reg_val(rd_addr_o) : 8'h00;
    end

    always @(negedge clk) begin
        if (wr_valid_o) begin
            wr_a_q.push_back(wr_addr_o);
            wr_d_q.push_back(wr_data_o);
        end
        if (rd_req_o) begin
            rd_a_q.push_back(rd_addr_o);
        end
        if (frame_err_o) begin
            ferr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wr_a_q.delete();
        wr_d_q.delete();
        rd_a_q.delete();
        ferr_cnt = 0;
    endtask

    task automatic spi_bit(input logic b, output logic rx);
        mosi_i = b;
        #HALF;
        sclk_i = 1'b1;
        rx = miso_o;
        #HALF;
        sclk_i = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        rx = '0;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic frame_start();
        cs_n_i = 1'b0;
        #HALF;
    endtask

    task automatic frame_end();
        #HALF;
        cs_n_i = 1'b1;
        #(4 * HALF);
    endtask

    initial begin
        logic [7:0] rx0, rx1, rx2, tmp;
        logic       rb;

        rst_i  = 1'b1;
        sclk_i = 1'b0;
        mosi_i = 1'b0;
        cs_n_i = 1'b1;
        ferr_cnt = 0;
        #3;
        #30;
        check("rst wr_valid", wr_valid_o, 1'b0);
        check("rst rd_req", rd_req_o, 1'b0);
        check("rst frame_err", frame_err_o, 1'b0);
        check("rst miso", miso_o, 1'b0);
        check("rst miso_oe", miso_oe_o, 1'b0);
        check("rst busy", busy_o, 1'b0);
        rst_i = 1'b0;
        #100;
        check("idle busy", busy_o, 1'b0);

        // 1: plain write frame with address increment
        clear_logs();
        frame_start();
        spi_byte(8'h05, tmp);
        spi_byte(8'hA5, tmp);
        check("t1 busy mid", busy_o, 1'b1);
        check("t1 miso_oe mid", miso_oe_o, 1'b1);
        check("t1 miso mid", miso_o, 1'b0);
        spi_byte(8'h3C, tmp);
        frame_end();
        check("t1 wr count", wr_a_q.size(), 2);
        check("t1 wr0 addr", wr_a_q[0], 7'h05);
        check("t1 wr0 data", wr_d_q[0], 8'hA5);
        check("t1 wr1 addr", wr_a_q[1], 7'h06);
        check("t1 wr1 data", wr_d_q[1], 8'h3C);
        check("t1 rd count", rd_a_q.size(), 0);
        check("t1 frame_err", ferr_cnt, 0);
        check("t1 miso_oe after", miso_oe_o, 1'b0);

        // 2: read frame, two dummy bytes
        clear_logs();
        frame_start();
        spi_byte(8'h85, rx0);
        spi_byte(8'h00, rx1);
        spi_byte(8'h00, rx2);
        frame_end();
        check("t2 miso cmd", rx0, 8'h00);
        check("t2 miso byte1", rx1, 8'h5A);
        check("t2 miso byte2", rx2, 8'hC3);
        check("t2 rd count", rd_a_q.size(), 3);
        check("t2 rd0 addr", rd_a_q[0], 7'h05);
        check("t2 rd1 addr", rd_a_q[1], 7'h06);
        check("t2 rd2 addr", rd_a_q[2], 7'h07);
        check("t2 wr count", wr_a_q.size(), 0);
        check("t2 miso after", miso_o, 1'b0);
        check("t2 frame_err", ferr_cnt, 0);

        // 3: cs released after 3 bits of the first data byte
        clear_logs();
        frame_start();
        spi_byte(8'h10, tmp);
        for (int i = 0; i < 3; i++) begin
            spi_bit(1'b1, rb);
        end
        frame_end();
        check("t3 frame_err pulses", ferr_cnt, 1);
        check("t3 wr count", wr_a_q.size(), 0);
        check("t3 rd count", rd_a_q.size(), 0);

        // 4: address wrap at 0x7F
        clear_logs();
        frame_start();
        spi_byte(8'h7F, tmp);
        spi_byte(8'h11, tmp);
        spi_byte(8'h22, tmp);
        frame_end();
        check("t4 wr count", wr_a_q.size(), 2);
        check("t4 wr0 addr", wr_a_q[0], 7'h7F);
        check("t4 wr0 data", wr_d_q[0], 8'h11);
        check("t4 wr1 addr", wr_a_q[1], 7'h00);
        check("t4 wr1 data", wr_d_q[1], 8'h22);

        // 5: reset in the middle of the command byte
        clear_logs();
        frame_start();
        for (int i = 7; i >= 4; i--) begin
            spi_bit(1'b0, rb);
        end
        rst_i = 1'b1;
        #20;
        check("t5 rst wr_valid", wr_valid_o, 1'b0);
        check("t5 rst wr_data", wr_data_o, 8'h00);
        check("t5 rst miso_oe", miso_oe_o, 1'b0);
        check("t5 rst busy", busy_o, 1'b0);
        check("t5 rst frame_err", frame_err_o, 1'b0);
        rst_i = 1'b0;
        spi_bit(1'b0, rb);
        spi_bit(1'b1, rb);
        spi_bit(1'b0, rb);
        spi_bit(1'b1, rb);
        spi_byte(8'hAB, tmp);
        frame_end();
        check("t5 remainder wr count", wr_a_q.size(), 0);
        check("t5 remainder frame_err", ferr_cnt, 0);
        clear_logs();
        frame_start();
        spi_byte(8'h01, tmp);
        spi_byte(8'h99, tmp);
        frame_end();
        check("t5 wr count", wr_a_q.size(), 1);
        check("t5 wr addr", wr_a_q[0], 7'h01);
        check("t5 wr data", wr_d_q[0], 8'h99);

        // 6: 8th rise of a data byte coincides with cs_n rising
        clear_logs();
        tmp = 8'h5C;
        frame_start();
        spi_byte(8'h20, rx0);
        for (int i = 7; i >= 1; i--) begin
            spi_bit(tmp[i], rb);
        end
        mosi_i = tmp[0];
        #HALF;
        sclk_i = 1'b1;
        cs_n_i = 1'b1;
        #HALF;
        sclk_i = 1'b0;
        #(4 * HALF);
        check("t6 wr count", wr_a_q.size(), 1);
        check("t6 wr addr", wr_a_q[0], 7'h20);
        check("t6 wr data", wr_d_q[0], 8'h5C);
        check("t6 frame_err", ferr_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
